// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline controller for the 5-stage RV32I core.
// Drives every PC-enable, stall, flush and redirect-select line. It sequences
// load-use bubbles, EX-resolved redirects and data-memory waits with a
// timeout. It also holds the post-reset flush state, the terminal halt state
// and the stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_SEL  = 5,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_SEL-1:0] rs1_id,
  input  logic [REG_SEL-1:0] rs2_id,
  input  logic               uses_rs1_id,
  input  logic               uses_rs2_id,
  input  logic [REG_SEL-1:0] rd_ex,
  input  logic               mem_read_ex,
  input  logic               redirect_ex,
  input  logic               dmem_req_mem,
  input  logic               dmem_ready,
  input  logic               halt_wb,
  output logic               en_pc,
  output logic               pc_src,
  output logic               stall_ifid,
  output logic               stall_idex,
  output logic               stall_exmem,
  output logic               stall_memwb,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic               flush_exmem,
  output logic               flush_memwb,
  output logic [1:0]         state,
  output logic               halted,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    S_INIT     = 2'b00,
    S_RUN      = 2'b01,
    S_MEM_WAIT = 2'b10,
    S_HALT     = 2'b11
  } state_e;

  localparam int              WC_W      = $clog2(MAX_WAIT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               load_use;
  logic               run_rules;
  logic               redirect_take;
  logic               stall_inc;

  // Load in EX whose destination feeds a source the ID instruction really reads.
  always_comb begin
    load_use = mem_read_ex && (rd_ex != '0) &&
               ((uses_rs1_id && (rs1_id == rd_ex)) ||
                (uses_rs2_id && (rs2_id == rd_ex)));
  end

  // Next-state and control outputs from current state and current inputs.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    en_pc         = 1'b1;
    pc_src        = 1'b0;
    stall_ifid    = 1'b0;
    stall_idex    = 1'b0;
    stall_exmem   = 1'b0;
    stall_memwb   = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_exmem   = 1'b0;
    flush_memwb   = 1'b0;
    run_rules     = 1'b0;
    redirect_take = 1'b0;

    case (state_q)
      S_INIT: begin
        en_pc       = 1'b0;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
        flush_memwb = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (halt_wb) begin
          en_pc       = 1'b0;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          stall_exmem = 1'b1;
          stall_memwb = 1'b1;
          state_d     = S_HALT;
        end else if (dmem_req_mem && !dmem_ready) begin
          // EX is frozen, so any redirect there is presented again later.
          en_pc       = 1'b0;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          stall_exmem = 1'b1;
          flush_memwb = 1'b1;
          wait_cnt_d  = WC_W'(1);
          state_d     = S_MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (halt_wb) begin
          en_pc       = 1'b0;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          stall_exmem = 1'b1;
          stall_memwb = 1'b1;
          state_d     = S_HALT;
        end else if (dmem_ready) begin
          // The access completes: behave as an ordinary RUN cycle right away.
          wait_cnt_d = '0;
          state_d    = S_RUN;
          run_rules  = 1'b1;
        end else begin
          en_pc       = 1'b0;
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          stall_exmem = 1'b1;
          flush_memwb = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            mem_timeout_d = 1'b1;
            state_d       = S_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
      end
      default: begin
        en_pc       = 1'b0;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        stall_memwb = 1'b1;
      end
    endcase

    // Redirect wins over load-use: the ID instruction is squashed anyway.
    if (run_rules) begin
      if (redirect_ex) begin
        pc_src        = 1'b1;
        flush_ifid    = 1'b1;
        flush_idex    = 1'b1;
        redirect_take = 1'b1;
      end else if (load_use) begin
        en_pc      = 1'b0;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end

    stall_inc = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !en_pc;
  end

  // State, wait counter, sticky timeout and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_INIT;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      if (stall_inc)     stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_take) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MAX_WAIT=4): each cycle's expected
// control response is queued as stimulus is driven, then popped and compared.
module tb_hazard_ctrl;

  localparam int REG_SEL  = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 32;

  logic clk, rst;
  logic [REG_SEL-1:0] rs1_id, rs2_id, rd_ex;
  logic uses_rs1_id, uses_rs2_id, mem_read_ex, redirect_ex;
  logic dmem_req_mem, dmem_ready, halt_wb;
  logic en_pc, pc_src;
  logic stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic [1:0] state;
  logic halted, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_SEL(REG_SEL), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect_ex(redirect_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready), .halt_wb(halt_wb),
    .en_pc(en_pc), .pc_src(pc_src),
    .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .state(state), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall/flush vectors are ordered {ifid, idex, exmem, memwb}.
  typedef struct {
    logic        en;
    logic        pc;
    logic [3:0]  stl;
    logic [3:0]  fl;
    logic [1:0]  st;
    logic        to;
    int unsigned scnt;
    int unsigned fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, want %0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic en, input logic pc, input logic [3:0] stl,
                              input logic [3:0] fl, input logic [1:0] st, input logic to,
                              input int unsigned scnt, input int unsigned fcnt);
    exp_t e;
    e.en = en; e.pc = pc; e.stl = stl; e.fl = fl; e.st = st; e.to = to;
    e.scnt = scnt; e.fcnt = fcnt;
    return e;
  endfunction

  function automatic exp_t run_idle(input int unsigned scnt, input int unsigned fcnt);
    return mk(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b01, 1'b0, scnt, fcnt);
  endfunction

  // Inputs were just driven at a falling edge: queue the expectation, sample
  // mid-phase, compare, then advance to the next falling edge.
  task automatic cycle(input exp_t e);
    exp_t g;
    logic [3:0] stl_o, fl_o;
    exp_q.push_back(e);
    #2;
    stl_o = {stall_ifid, stall_idex, stall_exmem, stall_memwb};
    fl_o  = {flush_ifid, flush_idex, flush_exmem, flush_memwb};
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      g = exp_q.pop_front();
      check("en_pc",       64'(en_pc),       64'(g.en));
      check("pc_src",      64'(pc_src),      64'(g.pc));
      check("stall_vec",   64'(stl_o),       64'(g.stl));
      check("flush_vec",   64'(fl_o),        64'(g.fl));
      check("state",       64'(state),       64'(g.st));
      check("halted",      64'(halted),      64'(g.st == 2'b11));
      check("mem_timeout", 64'(mem_timeout), 64'(g.to));
      check("stall_cnt",   64'(stall_cnt),   64'(g.scnt));
      check("flush_cnt",   64'(flush_cnt),   64'(g.fcnt));
      check("stall_and_flush", 64'(stl_o & fl_o), 64'd0);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    rs1_id = '0; rs2_id = '0; rd_ex = '0;
    uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; mem_read_ex = 1'b0;
    redirect_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0; halt_wb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; idle();
    cycle(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 2'b00, 1'b0, 0, 0));
    rst = 1'b1;
    cycle(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 2'b00, 1'b0, 0, 0));
    cycle(run_idle(0, 0));
  endtask

  initial begin
    rst = 1'b0; idle();
    @(negedge clk);

    // Reset, INIT, RUN.
    do_reset();

    // Load-use through rs2.
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; uses_rs2_id = 1'b1;
    cycle(mk(1'b0, 1'b0, 4'b1000, 4'b0100, 2'b01, 1'b0, 0, 0));
    idle(); cycle(run_idle(1, 0));
    // rd_ex = x0 never creates a hazard.
    mem_read_ex = 1'b1; rd_ex = 5'd0; rs2_id = 5'd0; uses_rs2_id = 1'b1;
    cycle(run_idle(1, 0));
    // Matching register that is not actually read.
    idle(); mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; uses_rs2_id = 1'b0;
    cycle(run_idle(1, 0));
    // Load-use through rs1.
    idle(); mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; uses_rs1_id = 1'b1;
    cycle(mk(1'b0, 1'b0, 4'b1000, 4'b0100, 2'b01, 1'b0, 1, 0));
    // Same registers but EX is not a load.
    mem_read_ex = 1'b0;
    cycle(run_idle(2, 0));

    // Redirect beats a simultaneous load-use.
    idle(); redirect_ex = 1'b1;
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; uses_rs2_id = 1'b1;
    cycle(mk(1'b1, 1'b1, 4'b0000, 4'b1100, 2'b01, 1'b0, 2, 0));
    idle(); cycle(run_idle(2, 1));

    // Memory wait of 3 cycles with a redirect held in EX throughout.
    redirect_ex = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b01, 1'b0, 2, 1));
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b10, 1'b0, 3, 1));
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b10, 1'b0, 4, 1));
    dmem_ready = 1'b1;
    cycle(mk(1'b1, 1'b1, 4'b0000, 4'b1100, 2'b10, 1'b0, 5, 1));
    idle(); cycle(run_idle(5, 2));

    // Halt while waiting on memory, then HALT is sticky.
    dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b01, 1'b0, 5, 2));
    halt_wb = 1'b1;
    cycle(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 2'b10, 1'b0, 6, 2));
    idle();
    cycle(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 2'b11, 1'b0, 7, 2));
    redirect_ex = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b1;
    cycle(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 2'b11, 1'b0, 7, 2));

    // Reset out of HALT.
    do_reset();

    // Timeout: ready held low for MAX_WAIT cycles.
    dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b01, 1'b0, 0, 0));
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b10, 1'b0, 1, 0));
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b10, 1'b0, 2, 0));
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b10, 1'b0, 3, 0));
    cycle(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 2'b11, 1'b1, 4, 0));
    idle();
    cycle(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 2'b11, 1'b1, 4, 0));

    // Reset clears the sticky timeout; then reset in the middle of a wait.
    do_reset();
    dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b01, 1'b0, 0, 0));
    cycle(mk(1'b0, 1'b0, 4'b1110, 4'b0001, 2'b10, 1'b0, 1, 0));
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
